// File: rtl/conv_pkg.sv
// Shared constants and types for the Sobel convolution output path.
package conv_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_PIX_W      = 12;

  // A 3x3 window is incomplete for the first two columns and rows.
  localparam int BORDER_TAPS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } framer_state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row position tracker; clear restarts at (0,0) and may coincide with advance.
module raster_counter #(
  parameter int IMG_WIDTH  = conv_pkg::DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = conv_pkg::DEF_IMG_HEIGHT,
  parameter int XW         = $clog2(IMG_WIDTH),
  parameter int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_col_o,
  output logic          last_pix_o
);

  localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_q, x_d, x_base;
  logic [YW-1:0] y_q, y_d, y_base;
  logic          col_end, row_end;

  // Position of the current beat: a clear takes effect on the same cycle.
  assign x_base  = clear_i ? '0 : x_q;
  assign y_base  = clear_i ? '0 : y_q;
  assign col_end = (x_base == X_MAX);
  assign row_end = (y_base == Y_MAX);

  always_comb begin
    x_d = x_base;
    y_d = y_base;
    if (advance_i) begin
      if (col_end) begin
        x_d = '0;
        y_d = row_end ? '0 : y_base + YW'(1);
      end else begin
        x_d = x_base + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o        = x_base;
  assign y_o        = y_base;
  assign last_col_o = col_end;
  assign last_pix_o = col_end & row_end;

endmodule

// File: rtl/conv_out_framer.sv
// Frames the convolution result stream with raster position, border zeroing and frame-length
// checking; 1-cycle registered latency. Optional binarize threshold under SOBEL_THRESH_EN.
module conv_out_framer
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIX_W      = DEF_PIX_W,
  parameter int XW         = $clog2(IMG_WIDTH),
  parameter int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [PIX_W-1:0] iPIXEL,
`ifdef SOBEL_THRESH_EN
  input  logic [PIX_W-1:0] iTHRESH,
`endif
  output logic             oDVAL,
  output logic [PIX_W-1:0] oPIXEL,
  output logic [XW-1:0]    oX,
  output logic [YW-1:0]    oY,
  output logic             oBORDER,
  output logic             oSOF,
  output logic             oEOL,
  output logic             oFRAME_DONE,
  output logic             oERR
);

  localparam logic [XW-1:0] X_BORDER = XW'(BORDER_TAPS);
  localparam logic [YW-1:0] Y_BORDER = YW'(BORDER_TAPS);

  framer_state_t state_q, state_d;
  logic          fval_q;
  logic          fval_rise, fval_fall;
  logic          clear, beat, err_d;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          last_col, last_pix;
  logic          border;
  logic [PIX_W-1:0] pix_val;

  logic             dval_q, border_q, sof_q, eol_q, done_q, err_q;
  logic [PIX_W-1:0] pix_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;

  assign fval_rise = iFVAL & ~fval_q;
  assign fval_fall = ~iFVAL & fval_q;

  raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .XW        (XW),
    .YW        (YW)
  ) u_raster (
    .clk_i     (iCLK),
    .rst_i     (iRST),
    .clear_i   (clear),
    .advance_i (beat),
    .x_o       (cnt_x),
    .y_o       (cnt_y),
    .last_col_o(last_col),
    .last_pix_o(last_pix)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    beat    = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (fval_rise) begin
          state_d = ACTIVE;
          clear   = 1'b1;
          err_d   = 1'b0;
          beat    = iDVAL;
        end
      end
      ACTIVE: begin
        beat = iDVAL;
        // A fall coinciding with the final beat is a clean frame end.
        if (iDVAL && last_pix) begin
          state_d = fval_fall ? IDLE : DONE;
        end else if (fval_fall) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (iDVAL) err_d = 1'b1;
        if (!iFVAL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign border = (cnt_x < X_BORDER) || (cnt_y < Y_BORDER);

`ifdef SOBEL_THRESH_EN
  assign pix_val = (iPIXEL >= iTHRESH) ? '1 : '0;
`else
  assign pix_val = iPIXEL;
`endif

  // fval_q resets high so a frame already in flight at reset release is not picked up.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= IDLE;
      fval_q   <= 1'b1;
      dval_q   <= 1'b0;
      pix_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      border_q <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fval_q   <= iFVAL;
      dval_q   <= beat;
      pix_q    <= (beat && !border) ? pix_val : '0;
      x_q      <= beat ? cnt_x : '0;
      y_q      <= beat ? cnt_y : '0;
      border_q <= beat && border;
      sof_q    <= beat && (cnt_x == '0) && (cnt_y == '0);
      eol_q    <= beat && last_col;
      done_q   <= beat && last_pix;
      err_q    <= err_d;
    end
  end

  assign oDVAL       = dval_q;
  assign oPIXEL      = pix_q;
  assign oX          = x_q;
  assign oY          = y_q;
  assign oBORDER     = border_q;
  assign oSOF        = sof_q;
  assign oEOL        = eol_q;
  assign oFRAME_DONE = done_q;
  assign oERR        = err_q;

endmodule

// File: doc/conv_out_framer.md
Name: conv_out_framer

Overview:
- Sink-side receiver for the Sobel convolution pixel stream.
- Accepts the convolution's per-beat result, aligned with the iDVAL beat that shifted in the newest window pixel.
- Tracks raster position per frame and zeroes pixels whose 3x3 window straddles the top or left border (incomplete window).
- Emits a registered, framed stream (valid, coordinates, SOF/EOL/done markers) to the downstream frame writer, and flags frame-length errors.

Parameters:
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- PIX_W, 12, pixel width; matches the convolution output width.
- XW, $clog2(IMG_WIDTH), width of the column coordinate.
- YW, $clog2(IMG_HEIGHT), width of the row coordinate.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  asynchronous reset, active-high.
- iFVAL  in  1  frame valid; a rising edge starts a frame.
- iDVAL  in  1  pixel beat valid; same beat qualifier fed to the convolution.
- iPIXEL  in  PIX_W  convolution magnitude result for this beat.
- iTHRESH  in  PIX_W  binarize threshold; present only with SOBEL_THRESH_EN.
- oDVAL  out  1  output beat valid.
- oPIXEL  out  PIX_W  framed pixel; 0 on border beats.
- oX  out  XW  column of the newest window pixel.
- oY  out  YW  row of the newest window pixel.
- oBORDER  out  1  beat is a border beat (oX<2 or oY<2).
- oSOF  out  1  first beat of frame (0,0).
- oEOL  out  1  last beat of a line (oX==IMG_WIDTH-1).
- oFRAME_DONE  out  1  one-cycle pulse with the final beat of the frame.
- oERR  out  1  sticky short/long-frame error; cleared at the next frame start.

Behaviour:
- Reset (asynchronous, iRST=1): all outputs 0, state IDLE, counters x=0 and y=0.
- Latency: exactly 1 cycle, iDVAL to oDVAL; all outputs are registered.
- Outputs other than oERR are valid only while oDVAL=1. oSOF, oEOL and oFRAME_DONE are 0 whenever oDVAL=0.
- State machine with states IDLE, ACTIVE, DONE. iFVAL is sampled each cycle; its previous value is held in a register.
- IDLE:
  - On iFVAL rising go to ACTIVE, clear x, y and oERR.
  - iDVAL beats in IDLE are dropped; oDVAL stays 0.
- ACTIVE:
  - Each iDVAL beat produces one output beat at (x,y), then x increments.
  - When x==IMG_WIDTH-1, x wraps to 0 and y increments.
  - Beat at (IMG_WIDTH-1, IMG_HEIGHT-1) asserts oFRAME_DONE and moves to DONE.
  - iFVAL falling while in ACTIVE (short frame) sets oERR and moves to IDLE.
- DONE:
  - iDVAL beats are dropped (oDVAL=0) and set oERR (long frame).
  - iFVAL low moves to IDLE.
- Simultaneous events:
  - iFVAL falling on the same cycle as the final beat: the beat is output, oFRAME_DONE pulses, no error, then go to IDLE.
  - iFVAL rising together with iDVAL: that beat is (0,0) with oSOF=1.
- Border rule: oPIXEL=0 and oBORDER=1 when x<2 or y<2; otherwise oPIXEL=iPIXEL.
- Reset mid-frame: immediate return to IDLE. A frame already in progress is not resumed; wait for the next iFVAL rising edge.
- Width rules:
  - No arithmetic on pixel data.
  - Counters are unsigned and never exceed IMG_WIDTH-1 / IMG_HEIGHT-1.
  - IMG_WIDTH and IMG_HEIGHT must each be at least 3.

Optional Feature:
- SOBEL_THRESH_EN defined:
  - iTHRESH port exists.
  - Non-border oPIXEL = all-ones when iPIXEL >= iTHRESH (unsigned compare), else 0.
  - Border beats are still 0. Latency is unchanged at 1 cycle.
- SOBEL_THRESH_EN undefined: iTHRESH port is absent and oPIXEL passes the magnitude through.

Decomposition:
- Package conv_pkg holds:
  - IMG_WIDTH/IMG_HEIGHT/PIX_W defaults, shared with the convolution and CONV_BUFFER sizing.
  - Enum framer_state_t {IDLE, ACTIVE, DONE}.
  - BORDER_TAPS=2 constant.
- One sub-module, raster_counter:
  - Inputs: clear, advance.
  - Outputs: x, y, last_col, last_pix.
  - Parameterized by IMG_WIDTH/IMG_HEIGHT; instanced once.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=3. Raise iFVAL, then 12 iDVAL beats carrying iPIXEL=0x100..0x10B:
  - oDVAL 12 beats, each 1 cycle late.
  - oPIXEL nonzero only at (2,2) and (3,2), as 0x10A and 0x10B.
  - oEOL at x=3; oSOF at the first beat; oFRAME_DONE with the 12th beat; oERR=0.
- Gapped iDVAL (1 on, 2 off) over a full frame: coordinates advance only on beats; output identical to the contiguous case.
- Drop iFVAL after 7 beats: oERR=1, FSM returns to IDLE. Next iFVAL rising clears oERR, and the first beat is (0,0) with oSOF.
- Send 13 beats in one frame: 13th beat dropped (no oDVAL), oERR=1 after it, and oFRAME_DONE was seen exactly once.
- Assert iRST at beat 5:
  - All outputs go 0 in the same cycle, asynchronously.
  - Release iRST with iFVAL still high: beats ignored until iFVAL falls and rises again.
- With SOBEL_THRESH_EN, iTHRESH=0x105: interior beat 0x10A gives 0xFFF, interior beat 0x104 gives 0x000, border beats give 0x000.
